// File: rtl/light_pkg.sv
`default_nettype none
// light_pkg: phase encoding, lamp decode and default phase lengths shared by
// the light-pattern generator and its consumer.
package light_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_GREEN   = 3'd1,
    PH_YELLOW  = 3'd2,
    PH_RED     = 3'd3,
    PH_DECEIVE = 3'd4
  } phase_e;

  typedef struct packed {
    logic green;
    logic yellow;
    logic red;
  } lamps_t;

  localparam lamps_t LAMPS_OFF     = '{green: 1'b0, yellow: 1'b0, red: 1'b0};
  localparam lamps_t LAMPS_GREEN   = '{green: 1'b1, yellow: 1'b0, red: 1'b0};
  localparam lamps_t LAMPS_YELLOW  = '{green: 1'b0, yellow: 1'b1, red: 1'b0};
  localparam lamps_t LAMPS_RED     = '{green: 1'b0, yellow: 1'b0, red: 1'b1};
  localparam lamps_t LAMPS_DECEIVE = '{green: 1'b1, yellow: 1'b0, red: 1'b1};

  localparam int GREEN_T_DEF   = 40;
  localparam int YELLOW_T_DEF  = 5;
  localparam int RED_T_DEF     = 20;
  localparam int DECEIVE_T_DEF = 3;
  localparam int TIMER_W_DEF   = 6;

  // Legal successor in the GREEN->YELLOW->RED ring; IDLE starts at GREEN.
  function automatic phase_e legal_successor(input phase_e p);
    case (p)
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_GREEN;
    endcase
  endfunction

  function automatic lamps_t lamp_decode(input phase_e p);
    case (p)
      PH_GREEN:   return LAMPS_GREEN;
      PH_YELLOW:  return LAMPS_YELLOW;
      PH_RED:     return LAMPS_RED;
      PH_DECEIVE: return LAMPS_DECEIVE;
      default:    return LAMPS_OFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/light_pattern_gen_phase_timer.sv
`default_nettype none
// phase_timer: loadable down-counter with hold; stops at zero and flags it.
module phase_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             hold,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (!hold && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/light_pattern_gen.sv
`default_nettype none
// light_pattern_gen: drives GREEN->YELLOW->RED lamp lines with programmable
// phase lengths and optional injection of an illegal green+red DECEIVE phase.
module light_pattern_gen
  import light_pkg::*;
#(
  parameter int GREEN_T   = GREEN_T_DEF,
  parameter int YELLOW_T  = YELLOW_T_DEF,
  parameter int RED_T     = RED_T_DEF,
  parameter int DECEIVE_T = DECEIVE_T_DEF,
  parameter int TIMER_W   = TIMER_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               hold,
  input  logic               force_red,
  input  logic               glitch_req,
  output logic               green,
  output logic               yellow,
  output logic               red,
  output logic [2:0]         phase,
  output logic [TIMER_W-1:0] timer,
  output logic               glitch_pending,
  output logic               cycle_done,
  output logic [7:0]         cycle_count
);

  localparam logic [TIMER_W-1:0] GREEN_LD   = TIMER_W'(GREEN_T - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LD  = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] RED_LD     = TIMER_W'(RED_T - 1);
  localparam logic [TIMER_W-1:0] DECEIVE_LD = TIMER_W'(DECEIVE_T - 1);

  phase_e             phase_q, phase_d;
  phase_e             resume_q, resume_d;
  phase_e             succ;
  lamps_t             lamps_q;
  logic               pending_q, pending_d;
  logic               done_q, done_d;
  logic [7:0]         count_q;
  logic               tmr_load, tmr_hold, tmr_zero;
  logic [TIMER_W-1:0] tmr_value;

  function automatic logic [TIMER_W-1:0] load_for(input phase_e p);
    case (p)
      PH_GREEN:   return GREEN_LD;
      PH_YELLOW:  return YELLOW_LD;
      PH_RED:     return RED_LD;
      PH_DECEIVE: return DECEIVE_LD;
      default:    return '0;
    endcase
  endfunction

  phase_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (tmr_load),
    .hold      (tmr_hold),
    .load_value(tmr_value),
    .count     (timer),
    .zero      (tmr_zero)
  );

  always_comb begin
    phase_d   = phase_q;
    resume_d  = resume_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_hold  = 1'b0;
    tmr_value = '0;
    // A DECEIVE phase resumes with the successor it displaced.
    succ      = (phase_q == PH_DECEIVE) ? resume_q : legal_successor(phase_q);

    if (!enable) begin
      phase_d   = PH_IDLE;
      pending_d = 1'b0;
      tmr_load  = 1'b1;
    end else if (phase_q == PH_IDLE) begin
      if (!hold) begin
        phase_d   = PH_GREEN;
        tmr_load  = 1'b1;
        tmr_value = GREEN_LD;
      end
    end else if (force_red) begin
      phase_d   = PH_RED;
      pending_d = 1'b0;
      tmr_load  = 1'b1;
      tmr_value = RED_LD;
    end else if (hold) begin
      tmr_hold  = 1'b1;
      pending_d = pending_q | glitch_req;
    end else if (tmr_zero) begin
      if (pending_q) begin
        phase_d  = PH_DECEIVE;
        resume_d = succ;
      end else begin
        phase_d = succ;
      end
      // A request landing on the boundary only queues for the next one.
      pending_d = pending_q ? 1'b0 : glitch_req;
      tmr_load  = 1'b1;
      tmr_value = load_for(phase_d);
      done_d    = (phase_d == PH_GREEN);
    end else begin
      pending_d = pending_q | glitch_req;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= PH_IDLE;
      resume_q  <= PH_GREEN;
      lamps_q   <= LAMPS_OFF;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      phase_q   <= phase_d;
      resume_q  <= resume_d;
      lamps_q   <= lamp_decode(phase_d);
      pending_q <= pending_d;
      done_q    <= done_d;
      count_q   <= count_q + {7'd0, done_d};
    end
  end

  assign green          = lamps_q.green;
  assign yellow         = lamps_q.yellow;
  assign red            = lamps_q.red;
  assign phase          = phase_q;
  assign glitch_pending = pending_q;
  assign cycle_done     = done_q;
  assign cycle_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_light_pattern_gen.sv
`default_nettype none
// tb_light_pattern_gen: directed stimulus with a stamped expectation queue
// drained by an independent negedge monitor.
module tb_light_pattern_gen;

  localparam int TW = 6;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          hold = 1'b0;
  logic          force_red = 1'b0;
  logic          glitch_req = 1'b0;
  logic          green, yellow, red, glitch_pending, cycle_done;
  logic [2:0]    phase;
  logic [TW-1:0] timer;
  logic [7:0]    cycle_count;

  light_pattern_gen dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .hold          (hold),
    .force_red     (force_red),
    .glitch_req    (glitch_req),
    .green         (green),
    .yellow        (yellow),
    .red           (red),
    .phase         (phase),
    .timer         (timer),
    .glitch_pending(glitch_pending),
    .cycle_done    (cycle_done),
    .cycle_count   (cycle_count)
  );

  always #5 clock = ~clock;

  localparam int S_GRN = 0, S_YEL = 1, S_RED = 2, S_PH = 3, S_TMR = 4,
                 S_PEND = 5, S_DONE = 6, S_CNT = 7;

  typedef struct packed {
    int stamp;
    int sel;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  function automatic string sel_name(input int sel);
    case (sel)
      S_GRN:   return "green";
      S_YEL:   return "yellow";
      S_RED:   return "red";
      S_PH:    return "phase";
      S_TMR:   return "timer";
      S_PEND:  return "glitch_pending";
      S_DONE:  return "cycle_done";
      default: return "cycle_count";
    endcase
  endfunction

  function automatic int actual(input int sel);
    case (sel)
      S_GRN:   return int'(green);
      S_YEL:   return int'(yellow);
      S_RED:   return int'(red);
      S_PH:    return int'(phase);
      S_TMR:   return int'(timer);
      S_PEND:  return int'(glitch_pending);
      S_DONE:  return int'(cycle_done);
      default: return int'(cycle_count);
    endcase
  endfunction

  // Monitor: compare every queued expectation whose stamp has been reached.
  always @(negedge clock) begin
    int i;
    int a;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].stamp <= edge_cnt) begin
        a = actual(exp_q[i].sel);
        n_checks++;
        if (a == exp_q[i].val) n_pass++;
        else $display("FAIL %s @edge %0d: got %0d expected %0d",
                      sel_name(exp_q[i].sel), edge_cnt, a, exp_q[i].val);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push_exp(input int stamp, input int sel, input int val);
    exp_t e;
    e.stamp = stamp;
    e.sel   = sel;
    e.val   = val;
    exp_q.push_back(e);
  endtask

  task automatic push_lamps(input int stamp, input int ph, input int g, input int y, input int r);
    push_exp(stamp, S_PH, ph);
    push_exp(stamp, S_GRN, g);
    push_exp(stamp, S_YEL, y);
    push_exp(stamp, S_RED, r);
  endtask

  task automatic push_reset_vals(input int stamp);
    push_lamps(stamp, 0, 0, 0, 0);
    push_exp(stamp, S_TMR, 0);
    push_exp(stamp, S_PEND, 0);
    push_exp(stamp, S_DONE, 0);
    push_exp(stamp, S_CNT, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (edge_cnt < n) tick();
  endtask

  initial begin
    int b;
    int c;

    tick();
    tick();
    push_reset_vals(edge_cnt);
    tick();
    reset_n = 1'b1;
    tick();

    // Full default cycle.
    b = edge_cnt;
    enable = 1'b1;
    push_lamps(b + 1, 1, 1, 0, 0);
    push_exp(b + 1, S_TMR, 39);
    push_exp(b + 1, S_DONE, 0);
    push_exp(b + 40, S_TMR, 0);
    push_exp(b + 40, S_GRN, 1);
    push_lamps(b + 41, 2, 0, 1, 0);
    push_exp(b + 41, S_TMR, 4);
    push_exp(b + 45, S_YEL, 1);
    push_lamps(b + 46, 3, 0, 0, 1);
    push_exp(b + 46, S_TMR, 19);
    push_exp(b + 65, S_RED, 1);
    push_exp(b + 65, S_DONE, 0);
    push_lamps(b + 66, 1, 1, 0, 0);
    push_exp(b + 66, S_DONE, 1);
    push_exp(b + 66, S_CNT, 1);
    push_exp(b + 66, S_TMR, 39);
    push_exp(b + 67, S_DONE, 0);

    // Hold for 10 edges at timer=20.
    wait_to(b + 85);
    hold = 1'b1;
    push_exp(b + 86, S_TMR, 20);
    push_exp(b + 95, S_TMR, 20);
    push_exp(b + 95, S_GRN, 1);
    wait_to(b + 95);
    hold = 1'b0;
    push_exp(b + 96, S_TMR, 19);
    push_exp(b + 115, S_GRN, 1);
    push_exp(b + 115, S_TMR, 0);
    push_lamps(b + 116, 2, 0, 1, 0);

    // Glitch during GREEN -> DECEIVE then YELLOW.
    push_exp(b + 141, S_DONE, 1);
    push_exp(b + 141, S_CNT, 2);
    wait_to(b + 150);
    glitch_req = 1'b1;
    tick();
    glitch_req = 1'b0;
    push_exp(b + 151, S_PEND, 1);
    push_exp(b + 180, S_PH, 1);
    push_lamps(b + 181, 4, 1, 0, 1);
    push_exp(b + 181, S_TMR, 2);
    push_exp(b + 181, S_PEND, 0);
    push_lamps(b + 183, 4, 1, 0, 1);
    push_lamps(b + 184, 2, 0, 1, 0);
    push_exp(b + 184, S_TMR, 4);
    push_lamps(b + 189, 3, 0, 0, 1);

    // force_red in YELLOW with a glitch pending.
    push_exp(b + 209, S_DONE, 1);
    push_exp(b + 209, S_CNT, 3);
    wait_to(b + 249);
    glitch_req = 1'b1;
    tick();
    glitch_req = 1'b0;
    push_exp(b + 250, S_PEND, 1);
    push_exp(b + 250, S_TMR, 3);
    wait_to(b + 251);
    force_red = 1'b1;
    push_exp(b + 251, S_PH, 2);
    push_exp(b + 251, S_TMR, 2);
    tick();
    force_red = 1'b0;
    push_lamps(b + 252, 3, 0, 0, 1);
    push_exp(b + 252, S_TMR, 19);
    push_exp(b + 252, S_PEND, 0);
    push_exp(b + 252, S_DONE, 0);
    push_exp(b + 271, S_RED, 1);
    push_lamps(b + 272, 1, 1, 0, 0);
    push_exp(b + 272, S_DONE, 1);
    push_exp(b + 272, S_CNT, 4);

    // enable low mid-RED, then restart.
    wait_to(b + 320);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    push_lamps(b + 321, 0, 0, 0, 0);
    push_exp(b + 321, S_TMR, 0);
    push_exp(b + 321, S_CNT, 4);
    push_lamps(b + 322, 1, 1, 0, 0);
    push_exp(b + 322, S_TMR, 39);
    push_exp(b + 322, S_CNT, 4);
    push_exp(b + 322, S_DONE, 0);

    // Asynchronous reset between edges, mid-GREEN.
    wait_to(b + 330);
    #2;
    reset_n = 1'b0;
    push_reset_vals(edge_cnt);
    tick();
    reset_n = 1'b1;

    // Long run to wrap cycle_count.
    c = edge_cnt;
    push_exp(c + 1, S_TMR, 39);
    push_exp(c + 1, S_CNT, 0);
    push_exp(c + 65 * 255 + 1, S_CNT, 255);
    push_exp(c + 65 * 256, S_CNT, 255);
    push_exp(c + 65 * 256 + 1, S_CNT, 0);
    push_exp(c + 65 * 256 + 1, S_DONE, 1);
    push_exp(c + 65 * 300 + 1, S_CNT, 44);
    push_exp(c + 65 * 300 + 1, S_GRN, 1);
    wait_to(c + 65 * 300 + 1);

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) tick();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      n_checks += exp_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/light_pattern_gen.md
Name: light_pattern_gen

Overview:
- Transmit-side counterpart of the light-pattern consumer. Drives the green/yellow/red lamp lines the consumer samples.
- Produces the legal repeating sequence GREEN→YELLOW→RED with programmable phase lengths, measured in clock cycles.
- On request, injects one illegal "deceive" phase (green and red lit together) so the consumer's deception detection can be exercised in-system.
- Sits between the test/config controller and the consumer; its lamp outputs connect directly to the consumer's green/yellow/red inputs.

Parameters:
- GREEN_T, 40, GREEN phase length in cycles.
- YELLOW_T, 5, YELLOW phase length in cycles.
- RED_T, 20, RED phase length in cycles.
- DECEIVE_T, 3, DECEIVE phase length in cycles.
- TIMER_W, 6, timer width. Every *_T must satisfy 1 ≤ T ≤ 2^TIMER_W.

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run the sequence; 0 forces IDLE.
- hold  in  1  freeze phase and timer.
- force_red  in  1  emergency: jump to RED.
- glitch_req  in  1  single-cycle request to insert one DECEIVE phase.
- green  out  1  green lamp line (registered).
- yellow  out  1  yellow lamp line (registered).
- red  out  1  red lamp line (registered).
- phase  out  3  IDLE=0, GREEN=1, YELLOW=2, RED=3, DECEIVE=4.
- timer  out  TIMER_W  cycles remaining in current phase minus 1.
- glitch_pending  out  1  a DECEIVE insertion is queued.
- cycle_done  out  1  one-cycle pulse on each RED→GREEN transition.
- cycle_count  out  8  completed cycles; wraps 255→0.

Behaviour:
- Reset (reset_n=0, asynchronous): phase=IDLE; all lamps 0; timer=0; glitch_pending=0; cycle_done=0; cycle_count=0.
- All outputs are registered. Lamps decode directly from the phase register:
  - GREEN: g=1
  - YELLOW: y=1
  - RED: r=1
  - DECEIVE: g=1, r=1
  - IDLE: all lamps off
- Priority per edge, highest first: enable=0 > force_red > hold > normal timing.
- enable=0: next edge goes to IDLE. Lamps 0, timer=0, glitch_pending cleared. cycle_count is retained.
- IDLE with enable=1: next edge enters GREEN with timer=GREEN_T-1. The first green=1 is visible one cycle after enable is sampled high.
- Normal timing:
  - If timer>0, timer decrements.
  - If timer==0, the next edge advances the phase and loads the new phase's T-1.
  - Each phase therefore lasts exactly its T cycles.
- Sequence: GREEN→YELLOW→RED→GREEN.
- RED→GREEN transition:
  - cycle_done=1 for exactly the first GREEN cycle.
  - cycle_count increments on that same edge.
- hold=1: phase, timer and lamps are frozen.
  - glitch_req is still latched during hold.
  - cycle_done is 0 while held.
- force_red=1 in GREEN/YELLOW/RED/DECEIVE: next edge enters RED with timer=RED_T-1 and clears glitch_pending.
  - If already in RED, the timer reloads.
  - force_red in IDLE is ignored.
  - Holding force_red high keeps reloading, so RED persists.
  - Leaving RED through force_red does not affect cycle_done; the pulse fires only on the normal RED→GREEN edge.
- glitch_req:
  - Sampled in any non-IDLE phase; sets glitch_pending.
  - Requests arriving while already pending are dropped (at most one queued).
  - At the next phase boundary (timer==0, no hold), DECEIVE is entered instead of the normal successor, with timer=DECEIVE_T-1. glitch_pending clears on that edge.
  - After DECEIVE, the sequence resumes with the successor that was skipped: e.g. GREEN→DECEIVE→YELLOW.
  - If RED→DECEIVE→GREEN, cycle_done fires on DECEIVE→GREEN.
- glitch_req coinciding with a phase boundary: the request is latched and takes effect at the following boundary, not the current one.
- Timer width: all T-1 values fit TIMER_W. Decrement never underflows, because a 0 always triggers a reload.
- Reset mid-phase: immediate return to the reset values above; no lamp glitch beyond the asynchronous clear.

Decomposition:
- Shared package light_pkg holds:
  - the phase enum (3-bit codes above)
  - lamp-decode constants
  - default T values shared with the consumer's timing checks
- Optional sub-module phase_timer: loadable down-counter with load, hold and zero-flag. The main FSM instantiates one.
- All other logic stays in light_pattern_gen.

Test Plan:
- Reset, then enable=1 with defaults → green high for cycles 1–40, yellow for 41–45, red for 46–65, green again at 66. cycle_done is a single pulse at 66 and cycle_count=1.
- hold=1 for 10 cycles starting at GREEN timer=20 → timer stays 20, green stays 1. The GREEN phase totals 50 cycles.
- glitch_req pulse during GREEN → glitch_pending=1. After GREEN ends, green=red=1 with phase=4 for 3 cycles, then YELLOW for 5 cycles. glitch_pending=0 after DECEIVE entry.
- force_red asserted for 1 cycle in YELLOW (timer=2) with a glitch pending → next cycle red=1, timer=19, glitch_pending=0. GREEN follows 20 cycles later with cycle_done=1.
- enable=0 mid-RED, then enable=1 → lamps 0 and phase=0 on the next edge. Restart is GREEN with timer=39; cycle_count is unchanged.
- reset_n asserted asynchronously mid-GREEN, between clock edges → all outputs go to reset values immediately. 300 consecutive full cycles make cycle_count wrap 255→0.
